// File: rtl/full_st1_ctrl_in_ctrl_pkg.sv
// Shared types and constants for the stage-1 input controller.
//   float_24_8  : one stream beat / memory word
//   rd_state_e  : reader FSM encoding (IDLE, RUN)
//   VEC_LEN     : beats per vector, one bank of the ping-pong memory
package full_st1_ctrl_in_ctrl_pkg;

    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned ADDR_WIDTH   = 6;
    localparam int unsigned CNT_WIDTH    = ADDR_WIDTH - 1;
    localparam int unsigned VEC_LEN      = 2 ** CNT_WIDTH;
    localparam int unsigned VCOUNT_WIDTH = 16;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(VEC_LEN - 1);

    typedef logic [DATA_WIDTH-1:0] float_24_8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rd_state_e;

endpackage

// File: rtl/full_st1_ctrl_in_ctrl_if.sv
// Beat stream from the stage-0 output controller.
//   data : float_24_8 beat
//   vld  : beat valid
//   fst  : first beat of a vector
//   rdy  : receiver can take a beat (accept = vld & rdy)
// master = producer side, slave = receiver side.
interface full_st1_ctrl_in_ctrl_if
    import full_st1_ctrl_in_ctrl_pkg::*;
;
    float_24_8 data;
    logic      vld;
    logic      fst;
    logic      rdy;

    modport master (output data, output vld, output fst, input rdy);
    modport slave  (input data, input vld, input fst, output rdy);

endinterface

// File: rtl/full_st1_ctrl_in_ctrl_pingpong_ctrl.sv
// Ping-pong bank bookkeeping and reader FSM.
//   clk, reset   : clock, synchronous active-high reset
//   wr_done      : last beat of a vector accepted into wr_bank
//   rd_done      : consumer finished with rd_bank (ignored unless RUN)
//   wr_bank      : bank currently being filled
//   rd_bank      : bank the consumer reads
//   full[1:0]    : per-bank full flags
//   active_start : 1-cycle pulse when a full bank is handed to the consumer
//   active       : consumer owns rd_bank
module full_st1_pingpong_ctrl
    import full_st1_ctrl_in_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_done,
    input  logic       rd_done,
    output logic       wr_bank,
    output logic       rd_bank,
    output logic [1:0] full,
    output logic       active_start,
    output logic       active
);

    rd_state_e state;
    rd_state_e state_next;
    logic      run_entry;
    logic      rd_release;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            full         <= '0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            active_start <= 1'b0;
        end else begin
            state        <= state_next;
            active_start <= run_entry;
            if (wr_done) begin
                wr_bank <= ~wr_bank;
            end
            if (rd_release) begin
                rd_bank <= ~rd_bank;
            end
            // Set and clear can hit the same cycle only on different banks.
            for (int unsigned b = 0; b < 2; b++) begin
                if (wr_done && (wr_bank == b[0])) begin
                    full[b] <= 1'b1;
                end else if (rd_release && (rd_bank == b[0])) begin
                    full[b] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (full[rd_bank]) state_next = RUN;
            RUN:     if (rd_done)       state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        active     = (state == RUN);
        run_entry  = (state == IDLE) && full[rd_bank];
        rd_release = (state == RUN) && rd_done;
    end

    // A bank being filled is never full, and only a full bank is read.
    wr_rd_same_bank: assert property (@(posedge clk) disable iff (reset)
        !(wr_done && rd_release && (wr_bank == rd_bank)));

endmodule

// File: rtl/full_st1_ctrl_in_ctrl.sv
// Stage-1 input controller: packs the stage-0 beat stream into a ping-pong
// data memory and hands full banks to the next stage.
//   clk, reset        : clock, synchronous active-high reset
//   stage_0_data_out  : beat stream (slave side, rdy driven here)
//   data_write_addr   : memory write address {wr_bank, wr_cnt}
//   data_valid        : memory write strobe
//   data_value        : memory write data
//   read_finish       : consumer done with rd_bank
//   active_start      : pulse, vector in rd_bank ready
//   active            : consumer owns rd_bank
//   rd_bank           : bank to read (read address MSB)
//   sync_err          : pulse, fst seen mid-vector
//   vec_count         : completed vectors since reset (wraps)
module full_st1_ctrl_in_ctrl
    import full_st1_ctrl_in_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    full_st1_ctrl_in_ctrl_if.slave  stage_0_data_out,
    output logic [ADDR_WIDTH-1:0]   data_write_addr,
    output logic                    data_valid,
    output float_24_8               data_value,
    input  logic                    read_finish,
    output logic                    active_start,
    output logic                    active,
    output logic                    rd_bank,
    output logic                    sync_err,
    output logic [VCOUNT_WIDTH-1:0] vec_count
);

    logic [CNT_WIDTH-1:0] wr_cnt;
    logic [CNT_WIDTH-1:0] addr_cnt;
    logic [1:0]           full;
    logic                 wr_bank;
    logic                 accept;
    logic                 resync;
    logic                 wr_done;

    // rdy comes from registers and reset only, never from vld.
    always_comb begin
        stage_0_data_out.rdy = ~full[wr_bank] & ~reset;
        accept   = stage_0_data_out.vld & stage_0_data_out.rdy;
        // fst mid-vector restarts the vector at word 0 of the same bank.
        resync   = accept & stage_0_data_out.fst & (wr_cnt != '0);
        addr_cnt = resync ? '0 : wr_cnt;
        wr_done  = accept & ~resync & (wr_cnt == LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_write_addr <= '0;
            data_valid      <= 1'b0;
            data_value      <= '0;
            wr_cnt          <= '0;
            sync_err        <= 1'b0;
            vec_count       <= '0;
        end else begin
            data_valid <= accept;
            sync_err   <= resync;
            if (accept) begin
                data_value      <= stage_0_data_out.data;
                data_write_addr <= {wr_bank, addr_cnt};
                if (resync) begin
                    wr_cnt <= CNT_WIDTH'(1);
                end else if (wr_done) begin
                    wr_cnt <= '0;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (wr_done) begin
                vec_count <= vec_count + 1'b1;
            end
        end
    end

    full_st1_pingpong_ctrl u_pingpong (
        .clk          (clk),
        .reset        (reset),
        .wr_done      (wr_done),
        .rd_done      (read_finish),
        .wr_bank      (wr_bank),
        .rd_bank      (rd_bank),
        .full         (full),
        .active_start (active_start),
        .active       (active)
    );

endmodule
